// File: rtl/branch_pred_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_pred_table
// Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//            counters. The fetch PC is looked up combinationally. The
//            fetch-time hit and prediction are carried through the s1 (decode)
//            barrier. Branch-unit decisions are committed against the PC that
//            is held in decode.
// Ports    : clk, rst_n             - clock (posedge), async active-low reset
//            pc_f                   - fetch PC
//            stall_s1, flush_s1     - decode barrier hold / squash
//            hit_f, pred_f, target_f- fetch-stage lookup result
//            hit_d, pred_d          - lookup result of the decode instruction
//            wr_tag, wr_pred        - allocate / counter-update requests
//            taken_d, target_d      - resolved direction and target in decode
// Revision : 1.0 - initial release
// ============================================================================
module branch_pred_table #(
    parameter int IDX_BITS = 4,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_f,
    input  logic            stall_s1,
    input  logic            flush_s1,
    output logic            hit_f,
    output logic            pred_f,
    output logic [PC_W-1:0] target_f,
    output logic            hit_d,
    output logic            pred_d,
    input  logic            wr_tag,
    input  logic            wr_pred,
    input  logic            taken_d,
    input  logic [PC_W-1:0] target_d
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = PC_W - IDX_BITS - 2;

    // Table storage
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    // s1 barrier
    logic [PC_W-1:0]  r_pc_d;
    logic             r_hit_d;
    logic             r_pred_d;

    logic [IDX_BITS-1:0] w_idx_f;
    logic [TAG_W-1:0]    w_tag_f;
    logic [IDX_BITS-1:0] w_idx_d;
    logic [TAG_W-1:0]    w_tag_d;
    logic                w_hit_f;
    logic                w_hit_d;
    logic                w_unused;

    assign w_idx_f = pc_f[IDX_BITS+1:2];
    assign w_tag_f = pc_f[PC_W-1:IDX_BITS+2];
    assign w_idx_d = r_pc_d[IDX_BITS+1:2];
    assign w_tag_d = r_pc_d[PC_W-1:IDX_BITS+2];

    // Word-aligned PCs: the byte-offset bits carry no information here.
    assign w_unused = ^{pc_f[1:0], r_pc_d[1:0]};

    // Lookup reads only registered table state, so a write in this cycle
    // becomes visible at the next cycle.
    assign w_hit_f  = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign hit_f    = w_hit_f;
    assign pred_f   = w_hit_f & r_ctr[w_idx_f][1];
    assign target_f = w_hit_f ? r_target[w_idx_f] : '0;

    // The entry may have been replaced since this instruction was fetched,
    // so the counter update re-checks the tag against pc_d.
    assign w_hit_d  = r_valid[w_idx_d] && (r_tag[w_idx_d] == w_tag_d);

    assign hit_d    = r_hit_d;
    assign pred_d   = r_pred_d;

    // s1 barrier: flush wins over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_d   <= '0;
            r_hit_d  <= 1'b0;
            r_pred_d <= 1'b0;
        end else if (flush_s1) begin
            r_pc_d   <= pc_f;
            r_hit_d  <= 1'b0;
            r_pred_d <= 1'b0;
        end else if (!stall_s1) begin
            r_pc_d   <= pc_f;
            r_hit_d  <= w_hit_f;
            r_pred_d <= pred_f;
        end
    end

    // Table update. A stall blocks the update; a flush does not, because the
    // branch unit flushes while it commits its own correction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (!stall_s1) begin
            if (wr_tag) begin
                // Allocation sets a weak counter; it overrides wr_pred.
                r_valid[w_idx_d]  <= 1'b1;
                r_tag[w_idx_d]    <= w_tag_d;
                r_target[w_idx_d] <= target_d;
                r_ctr[w_idx_d]    <= taken_d ? 2'b10 : 2'b01;
            end else if (wr_pred && w_hit_d) begin
                if (taken_d) begin
                    r_target[w_idx_d] <= target_d;
                    if (r_ctr[w_idx_d] != 2'b11) begin
                        r_ctr[w_idx_d] <= r_ctr[w_idx_d] + 2'b01;
                    end
                end else if (r_ctr[w_idx_d] != 2'b00) begin
                    r_ctr[w_idx_d] <= r_ctr[w_idx_d] - 2'b01;
                end
            end
        end
    end

endmodule
`default_nettype wire
